// File: rtl/reg_file_sb_if.sv
// Bus bundle for reg_file_sb: writeback, two read ports, issue, and scoreboard outputs.
interface reg_file_sb_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              Reg_write;
  logic [ADDR_W-1:0] Write_reg;
  logic [DATA_W-1:0] Write_data;
  logic [ADDR_W-1:0] Read_reg1;
  logic [ADDR_W-1:0] Read_reg2;
  logic              Choose_reg;
  logic              Issue_valid;
  logic [ADDR_W-1:0] Issue_reg;
  logic [DATA_W-1:0] Read_data1;
  logic [DATA_W-1:0] Read_data2;
  logic              Busy1;
  logic              Busy2;
  logic              Stall;
  logic [ADDR_W:0]   Busy_count;

  modport master (
    output Reg_write, Write_reg, Write_data, Read_reg1, Read_reg2, Choose_reg,
           Issue_valid, Issue_reg,
    input  Read_data1, Read_data2, Busy1, Busy2, Stall, Busy_count
  );

  modport slave (
    input  Reg_write, Write_reg, Write_data, Read_reg1, Read_reg2, Choose_reg,
           Issue_valid, Issue_reg,
    output Read_data1, Read_data2, Busy1, Busy2, Stall, Busy_count
  );
endinterface

// File: rtl/reg_file_sb.sv
// Register file with busy scoreboard for the pipelined datapath.
// Optional BYPASS_EN macro enables same-cycle write-to-read forwarding.
module reg_file_sb #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 5,
  parameter int ZERO_REG   = 1,
  parameter int INIT_INDEX = 1
) (
  input logic         clk,
  input logic         reset,
  reg_file_sb_if.slave bus
);
  localparam int unsigned   DEPTH   = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] MAX_CNT = (ADDR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  busy;
  logic [ADDR_W:0]   busy_count;

  logic wr_ok, iss_ok, set_rise, clr_fall;

  assign wr_ok  = bus.Reg_write   && !((ZERO_REG != 0) && (bus.Write_reg == '0));
  assign iss_ok = bus.Issue_valid && !((ZERO_REG != 0) && (bus.Issue_reg == '0));

  // A same-index issue overrides the clear, so that case never counts as a fall.
  assign set_rise = iss_ok && !busy[bus.Issue_reg];
  assign clr_fall = bus.Reg_write && busy[bus.Write_reg] &&
                    !(iss_ok && (bus.Issue_reg == bus.Write_reg));

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++)
        mem[i] <= (INIT_INDEX != 0) ? DATA_W'(i) : '0;
      busy       <= '0;
      busy_count <= '0;
    end else begin
      if (wr_ok)
        mem[bus.Write_reg] <= bus.Write_data;
      if (bus.Reg_write)
        busy[bus.Write_reg] <= 1'b0;
      if (iss_ok)
        busy[bus.Issue_reg] <= 1'b1;
      if (set_rise && !clr_fall && (busy_count != MAX_CNT))
        busy_count <= busy_count + 1'b1;
      else if (clr_fall && !set_rise && (busy_count != '0))
        busy_count <= busy_count - 1'b1;
    end
  end

  logic [DATA_W-1:0] d1, d2;
  logic              b1, b2;

  always_comb begin
    d1 = ((ZERO_REG != 0) && (bus.Read_reg1 == '0)) ? '0 : mem[bus.Read_reg1];
    d2 = ((ZERO_REG != 0) && (bus.Read_reg2 == '0)) ? '0 : mem[bus.Read_reg2];
    b1 = busy[bus.Read_reg1];
    b2 = busy[bus.Read_reg2];
`ifdef BYPASS_EN
    // Forwarded port sees the retiring producer's data; busy survives only a re-issue.
    if (wr_ok && (bus.Write_reg == bus.Read_reg1)) begin
      d1 = bus.Write_data;
      b1 = b1 & bus.Issue_valid & (bus.Issue_reg == bus.Read_reg1);
    end
    if (wr_ok && (bus.Write_reg == bus.Read_reg2)) begin
      d2 = bus.Write_data;
      b2 = b2 & bus.Issue_valid & (bus.Issue_reg == bus.Read_reg2);
    end
`else
`endif
  end

  assign bus.Read_data1 = d1;
  assign bus.Read_data2 = bus.Choose_reg ? d2 : '0;
  assign bus.Busy1      = b1;
  assign bus.Busy2      = bus.Choose_reg & b2;
  assign bus.Stall      = bus.Busy1 | bus.Busy2;
  assign bus.Busy_count = busy_count;
endmodule

// File: tb/tb_reg_file_sb.sv
// Self-checking bench for reg_file_sb: per-cycle model compare plus directed literal checks.
module tb_reg_file_sb;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  reg_file_sb_if #(.DATA_W(32), .ADDR_W(5)) bus ();

  reg_file_sb #(
    .DATA_W    (32),
    .ADDR_W    (5),
    .ZERO_REG  (1),
    .INIT_INDEX(1)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // Model: register contents and a set of outstanding destinations.
  logic [31:0] m_mem [32];
  bit          m_busy [32];
  bit          armed = 0;

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        m_mem[i]  = i;
        m_busy[i] = 0;
      end
      armed = 1;
    end else if (armed) begin
      if (bus.Reg_write) begin
        if (bus.Write_reg != 0) m_mem[bus.Write_reg] = bus.Write_data;
        m_busy[bus.Write_reg] = 0;
      end
      if (bus.Issue_valid && bus.Issue_reg != 0) m_busy[bus.Issue_reg] = 1;
    end
  end

  function automatic logic [31:0] exp_rd(input logic [4:0] idx);
    if (idx == 0) return 32'h0;
`ifdef BYPASS_EN
    if (bus.Reg_write && bus.Write_reg == idx) return bus.Write_data;
`endif
    return m_mem[idx];
  endfunction

  function automatic logic exp_busy(input logic [4:0] idx);
    logic b;
    b = m_busy[idx];
`ifdef BYPASS_EN
    if (bus.Reg_write && bus.Write_reg == idx && idx != 0)
      b = b && bus.Issue_valid && (bus.Issue_reg == idx);
`endif
    return b;
  endfunction

  function automatic int exp_count();
    int c = 0;
    for (int i = 0; i < 32; i++) c += m_busy[i];
    return c;
  endfunction

  always @(negedge clk) begin
    if (armed) begin
      logic e1, e2;
      e1 = exp_busy(bus.Read_reg1);
      e2 = bus.Choose_reg && exp_busy(bus.Read_reg2);
      chk("m_rd1",   bus.Read_data1, exp_rd(bus.Read_reg1));
      chk("m_rd2",   bus.Read_data2, bus.Choose_reg ? exp_rd(bus.Read_reg2) : 32'h0);
      chk("m_busy1", 32'(bus.Busy1), 32'(e1));
      chk("m_busy2", 32'(bus.Busy2), 32'(e2));
      chk("m_stall", 32'(bus.Stall), 32'(e1 | e2));
      chk("m_count", 32'(bus.Busy_count), exp_count());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.Reg_write   = 0;
    bus.Write_reg   = '0;
    bus.Write_data  = '0;
    bus.Issue_valid = 0;
    bus.Issue_reg   = '0;
  endtask

  initial begin
    reset = 1;
    idle();
    bus.Read_reg1  = 5'd7;
    bus.Read_reg2  = 5'd31;
    bus.Choose_reg = 1;
    tick();
    tick();
    reset = 0;
    #2;
    chk("reset_rd1",   bus.Read_data1, 32'd7);
    chk("reset_rd2",   bus.Read_data2, 32'd31);
    chk("reset_count", 32'(bus.Busy_count), 32'd0);
    chk("reset_stall", 32'(bus.Stall), 32'd0);

    bus.Reg_write = 1; bus.Write_reg = 5'd5; bus.Write_data = 32'hDEADBEEF;
    tick();
    idle();
    bus.Read_reg1 = 5'd5; bus.Read_reg2 = 5'd5; bus.Choose_reg = 0;
    #2;
    chk("write_rd1",   bus.Read_data1, 32'hDEADBEEF);
    chk("choose0_rd2", bus.Read_data2, 32'h0);
    chk("choose0_b2",  32'(bus.Busy2), 32'd0);

    bus.Choose_reg = 1;
    bus.Reg_write = 1; bus.Write_reg = 5'd0; bus.Write_data = 32'h1234;
    bus.Issue_valid = 1; bus.Issue_reg = 5'd0;
    tick();
    idle();
    bus.Read_reg1 = 5'd0;
    #2;
    chk("zero_rd1",   bus.Read_data1, 32'h0);
    chk("zero_busy1", 32'(bus.Busy1), 32'd0);
    chk("zero_count", 32'(bus.Busy_count), 32'd0);

    bus.Issue_valid = 1; bus.Issue_reg = 5'd3;
    tick();
    idle();
    bus.Read_reg1 = 5'd3;
    #2;
    chk("issue_busy1", 32'(bus.Busy1), 32'd1);
    chk("issue_stall", 32'(bus.Stall), 32'd1);
    chk("issue_count", 32'(bus.Busy_count), 32'd1);
    bus.Reg_write = 1; bus.Write_reg = 5'd3; bus.Write_data = 32'h333;
    #2;
`ifdef BYPASS_EN
    chk("wb_same_stall", 32'(bus.Stall), 32'd0);
    chk("wb_same_rd1",   bus.Read_data1, 32'h333);
`else
    chk("wb_same_stall", 32'(bus.Stall), 32'd1);
    chk("wb_same_rd1",   bus.Read_data1, 32'd3);
`endif
    tick();
    idle();
    #2;
    chk("wb_busy1", 32'(bus.Busy1), 32'd0);
    chk("wb_count", 32'(bus.Busy_count), 32'd0);
    chk("wb_rd1",   bus.Read_data1, 32'h333);

    bus.Issue_valid = 1; bus.Issue_reg = 5'd9;
    tick();
    bus.Reg_write = 1; bus.Write_reg = 5'd9; bus.Write_data = 32'hA5A5;
    tick();
    idle();
    bus.Read_reg1 = 5'd9;
    #2;
    chk("setwins_rd1",   bus.Read_data1, 32'hA5A5);
    chk("setwins_busy1", 32'(bus.Busy1), 32'd1);
    chk("setwins_count", 32'(bus.Busy_count), 32'd1);
    bus.Reg_write = 1; bus.Write_reg = 5'd9; bus.Write_data = 32'hA5A5;
    tick();
    idle();

    bus.Issue_valid = 1; bus.Issue_reg = 5'd10;
    tick();
    bus.Issue_reg = 5'd11;
    bus.Reg_write = 1; bus.Write_reg = 5'd10; bus.Write_data = 32'h10;
    tick();
    idle();
    bus.Read_reg1 = 5'd11; bus.Read_reg2 = 5'd10;
    #2;
    chk("netzero_count", 32'(bus.Busy_count), 32'd1);
    chk("netzero_busy1", 32'(bus.Busy1), 32'd1);
    chk("netzero_busy2", 32'(bus.Busy2), 32'd0);
    bus.Reg_write = 1; bus.Write_reg = 5'd11; bus.Write_data = 32'h11;
    tick();
    idle();

    bus.Issue_valid = 1; bus.Issue_reg = 5'd1;
    tick();
    bus.Issue_reg = 5'd2;
    tick();
    reset = 1; bus.Issue_reg = 5'd4;
    tick();
    reset = 0;
    idle();
    bus.Read_reg1 = 5'd5; bus.Read_reg2 = 5'd9;
    #2;
    chk("rst_mid_rd1",   bus.Read_data1, 32'd5);
    chk("rst_mid_rd2",   bus.Read_data2, 32'd9);
    chk("rst_mid_count", 32'(bus.Busy_count), 32'd0);
    chk("rst_mid_stall", 32'(bus.Stall), 32'd0);
    bus.Read_reg1 = 5'd1; bus.Read_reg2 = 5'd4;
    #2;
    chk("rst_mid_busy", 32'({bus.Busy1, bus.Busy2}), 32'd0);
    bus.Reg_write = 1; bus.Write_reg = 5'd1; bus.Write_data = 32'h77;
    tick();
    idle();
    #2;
    chk("stale_wb_rd1",   bus.Read_data1, 32'h77);
    chk("stale_wb_count", 32'(bus.Busy_count), 32'd0);

    for (int i = 1; i < 32; i++) begin
      bus.Issue_valid = 1; bus.Issue_reg = 5'(i);
      tick();
    end
    idle();
    #2;
    chk("fill_count", 32'(bus.Busy_count), 32'd31);
    bus.Issue_valid = 1; bus.Issue_reg = 5'd5;
    tick();
    idle();
    #2;
    chk("rebusy_count", 32'(bus.Busy_count), 32'd31);
    for (int i = 31; i >= 1; i--) begin
      bus.Reg_write = 1; bus.Write_reg = 5'(i); bus.Write_data = 32'(i * 16);
      tick();
    end
    idle();
    bus.Read_reg1 = 5'd31;
    #2;
    chk("drain_count", 32'(bus.Busy_count), 32'd0);
    chk("drain_rd1",   bus.Read_data1, 32'h1F0);
    bus.Reg_write = 1; bus.Write_reg = 5'd6; bus.Write_data = 32'h66;
    tick();
    idle();
    #2;
    chk("idle_clear_count", 32'(bus.Busy_count), 32'd0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
